floo_vc_out_credit_alloc: RTL and testbench

- Per-output-port block of the VC router. Tracks downstream credits for each virtual channel and selects an output VC for the winning head flit, using FVADA: preferred VC first, else lowest-index eligible VC.
- Holds wormhole ownership of a VC from head flit to tail flit.
- Sits between global switch allocation and VC assignment; one instance per output port.

---
 rtl/floo_vc_out_credit_alloc.sv | 121 ++++++++++++
 tb/tb_floo_vc_out_credit_alloc.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/floo_vc_out_credit_alloc.sv
// Per-output-port downstream credit tracking, wormhole VC ownership and
// output VC selection (preferred VC first, else lowest-index eligible VC).
module floo_vc_out_credit_alloc #(
    parameter int NumVC       = 4,
    parameter int NumVCWidth  = 2,
    parameter int VCDepth     = 2,
    parameter int CreditWidth = $clog2(VCDepth + 1),
    parameter int WormholeEn  = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  credit_v_i,
    input  logic [NumVCWidth-1:0] credit_id_i,
    input  logic [NumVC-1:0]      vc_allowed_i,
    input  logic [NumVCWidth-1:0] vc_pref_i,
    output logic                  vc_sel_v_o,
    output logic [NumVCWidth-1:0] vc_sel_id_o,
    input  logic                  assign_v_i,
    input  logic [NumVCWidth-1:0] assign_id_i,
    input  logic                  assign_head_i,
    input  logic                  assign_tail_i,
    output logic [NumVC-1:0]      vc_credit_ok_o,
    output logic [NumVC-1:0]      vc_locked_o,
    output logic                  credit_err_o
);

    logic [CreditWidth-1:0] r_cnt [NumVC];
    logic [NumVC-1:0]       r_lock;
    logic                   r_err;

    logic [CreditWidth-1:0] w_cnt_nxt [NumVC];
    logic [NumVC-1:0]       w_lock_nxt;
    logic [NumVC-1:0]       w_dec;
    logic [NumVC-1:0]       w_inc;
    logic [NumVC-1:0]       w_credit_ok;
    logic [NumVC-1:0]       w_elig;
    logic                   w_err_set;
    logic                   w_pref_hit;
    logic [NumVCWidth-1:0]  w_low_id;

    always_comb begin
        w_credit_ok = '0;
        for (int v = 0; v < NumVC; v++) begin
            w_credit_ok[v] = (r_cnt[v] != '0);
        end
        w_elig = vc_allowed_i & w_credit_ok & ~r_lock;
    end

    always_comb begin
        w_pref_hit = 1'b0;
        w_low_id   = '0;
        for (int v = NumVC - 1; v >= 0; v--) begin
            if (w_elig[v]) begin
                w_low_id = NumVCWidth'(v);
            end
            if (w_elig[v] && (vc_pref_i == NumVCWidth'(v))) begin
                w_pref_hit = 1'b1;
            end
        end
    end

    assign vc_sel_v_o     = |w_elig;
    assign vc_sel_id_o    = !vc_sel_v_o ? '0 : (w_pref_hit ? vc_pref_i : w_low_id);
    assign vc_credit_ok_o = w_credit_ok;
    assign vc_locked_o    = r_lock;
    assign credit_err_o   = r_err;

    // An out-of-range assign_id_i matches no VC, so it only raises the error.
    always_comb begin
        w_err_set  = assign_v_i && (int'(assign_id_i) >= NumVC);
        w_dec      = '0;
        w_inc      = '0;
        w_lock_nxt = r_lock;
        for (int v = 0; v < NumVC; v++) begin
            w_dec[v]     = assign_v_i && (assign_id_i == NumVCWidth'(v));
            w_inc[v]     = credit_v_i && (credit_id_i == NumVCWidth'(v));
            w_cnt_nxt[v] = r_cnt[v];
            if (w_dec[v] && !w_inc[v]) begin
                if (r_cnt[v] == '0) begin
                    w_err_set = 1'b1;
                end else begin
                    w_cnt_nxt[v] = r_cnt[v] - CreditWidth'(1);
                end
            end else if (w_inc[v] && !w_dec[v]) begin
                if (r_cnt[v] == CreditWidth'(VCDepth)) begin
                    w_err_set = 1'b1;
                end else begin
                    w_cnt_nxt[v] = r_cnt[v] + CreditWidth'(1);
                end
            end
            if (WormholeEn == 0) begin
                w_lock_nxt[v] = 1'b0;
            end else if (w_dec[v]) begin
                if (assign_head_i && r_lock[v]) begin
                    w_err_set = 1'b1;
                end else if (assign_head_i && !assign_tail_i) begin
                    w_lock_nxt[v] = 1'b1;
                end else if (assign_tail_i) begin
                    w_lock_nxt[v] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int v = 0; v < NumVC; v++) begin
                r_cnt[v] <= CreditWidth'(VCDepth);
            end
            r_lock <= '0;
            r_err  <= 1'b0;
        end else begin
            for (int v = 0; v < NumVC; v++) begin
                r_cnt[v] <= w_cnt_nxt[v];
            end
            r_lock <= w_lock_nxt;
            r_err  <= r_err | w_err_set;
        end
    end

endmodule

// File: tb/tb_floo_vc_out_credit_alloc.sv
// Scoreboard bench: the stimulus process pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_floo_vc_out_credit_alloc;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       credit_v_i;
    logic [1:0] credit_id_i;
    logic [3:0] vc_allowed_i;
    logic [1:0] vc_pref_i;
    logic       vc_sel_v_o;
    logic [1:0] vc_sel_id_o;
    logic       assign_v_i;
    logic [1:0] assign_id_i;
    logic       assign_head_i;
    logic       assign_tail_i;
    logic [3:0] vc_credit_ok_o;
    logic [3:0] vc_locked_o;
    logic       credit_err_o;

    floo_vc_out_credit_alloc #(
        .NumVC(4), .NumVCWidth(2), .VCDepth(2), .WormholeEn(1)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .credit_v_i(credit_v_i), .credit_id_i(credit_id_i),
        .vc_allowed_i(vc_allowed_i), .vc_pref_i(vc_pref_i),
        .vc_sel_v_o(vc_sel_v_o), .vc_sel_id_o(vc_sel_id_o),
        .assign_v_i(assign_v_i), .assign_id_i(assign_id_i),
        .assign_head_i(assign_head_i), .assign_tail_i(assign_tail_i),
        .vc_credit_ok_o(vc_credit_ok_o), .vc_locked_o(vc_locked_o),
        .credit_err_o(credit_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string      name;
        logic       sel_v;
        logic [1:0] sel_id;
        logic [3:0] ok;
        logic [3:0] lock;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always @(negedge clk_i) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_tests++;
            if (vc_sel_v_o !== e.sel_v || vc_sel_id_o !== e.sel_id ||
                vc_credit_ok_o !== e.ok || vc_locked_o !== e.lock ||
                credit_err_o !== e.err) begin
                n_fail++;
                $display("FAIL %s: got sel_v=%b sel_id=%0d ok=%b lock=%b err=%b, want sel_v=%b sel_id=%0d ok=%b lock=%b err=%b",
                         e.name, vc_sel_v_o, vc_sel_id_o, vc_credit_ok_o, vc_locked_o,
                         credit_err_o, e.sel_v, e.sel_id, e.ok, e.lock, e.err);
            end
        end
    end

    task automatic expect_out(input string name, input logic sel_v, input logic [1:0] sel_id,
                              input logic [3:0] ok, input logic [3:0] lock, input logic err);
        exp_t e;
        e.name = name; e.sel_v = sel_v; e.sel_id = sel_id;
        e.ok = ok; e.lock = lock; e.err = err;
        exp_q.push_back(e);
        @(negedge clk_i);
        #1;
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
        assign_v_i = 1'b0; assign_head_i = 1'b0; assign_tail_i = 1'b0;
        credit_v_i = 1'b0;
    endtask

    task automatic send(input logic [1:0] id, input logic head, input logic tail);
        assign_v_i = 1'b1; assign_id_i = id; assign_head_i = head; assign_tail_i = tail;
    endtask

    task automatic credit(input logic [1:0] id);
        credit_v_i = 1'b1; credit_id_i = id;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        cyc(); cyc();
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; credit_v_i = 1'b0; credit_id_i = '0;
        vc_allowed_i = 4'b1111; vc_pref_i = 2'd2;
        assign_v_i = 1'b0; assign_id_i = '0; assign_head_i = 1'b0; assign_tail_i = 1'b0;
        #1;
        do_reset();
        expect_out("reset", 1, 2, 4'b1111, 4'b0000, 0);

        // two single-flit sends on VC2, then a credit back
        send(2, 1, 1); cyc();
        expect_out("send1", 1, 2, 4'b1111, 4'b0000, 0);
        send(2, 1, 1); cyc();
        expect_out("send2_empty", 1, 0, 4'b1011, 4'b0000, 0);
        credit(2); cyc();
        expect_out("credit_back", 1, 2, 4'b1111, 4'b0000, 0);

        // wormhole on VC1
        vc_pref_i = 2'd1;
        expect_out("pref1", 1, 1, 4'b1111, 4'b0000, 0);
        send(1, 1, 0); cyc();
        expect_out("head_lock", 1, 0, 4'b1111, 4'b0010, 0);
        send(1, 0, 0); credit(1); cyc();
        expect_out("body1", 1, 0, 4'b1111, 4'b0010, 0);
        send(1, 0, 0); credit(1); cyc();
        expect_out("body2", 1, 0, 4'b1111, 4'b0010, 0);
        send(1, 0, 1); cyc();
        expect_out("tail_free", 1, 0, 4'b1101, 4'b0000, 0);
        credit(1); cyc();
        expect_out("c1_back", 1, 1, 4'b1111, 4'b0000, 0);

        // simultaneous send and credit on VC3 at cnt=1
        vc_pref_i = 2'd3;
        send(3, 1, 1); cyc();
        send(3, 1, 1); credit(3); cyc();
        expect_out("simul", 1, 3, 4'b1111, 4'b0000, 0);
        send(3, 1, 1); cyc();
        expect_out("simul_cnt1", 1, 0, 4'b0111, 4'b0000, 0);
        credit(3); cyc();
        expect_out("c3_back", 1, 3, 4'b1111, 4'b0000, 0);

        // overflow on VC0: counter must saturate at VCDepth
        credit(0); cyc();
        expect_out("overflow", 1, 3, 4'b1111, 4'b0000, 1);
        send(0, 1, 1); cyc();
        send(0, 1, 1); cyc();
        expect_out("ovf_hold", 1, 3, 4'b1110, 4'b0000, 1);
        cyc();
        expect_out("err_sticky", 1, 3, 4'b1110, 4'b0000, 1);

        // reset while VC1 owned and empty
        send(1, 1, 0); cyc();
        expect_out("owned_empty", 1, 3, 4'b1100, 4'b0010, 1);
        do_reset();
        expect_out("reset_mid", 1, 3, 4'b1111, 4'b0000, 0);
        vc_allowed_i = 4'b0000;
        expect_out("none_allowed", 0, 0, 4'b1111, 4'b0000, 0);
        vc_allowed_i = 4'b1010; vc_pref_i = 2'd2;
        expect_out("pref_masked", 1, 1, 4'b1111, 4'b0000, 0);

        // head flit onto an owned VC
        vc_allowed_i = 4'b1111; vc_pref_i = 2'd0;
        send(2, 1, 0); cyc();
        send(2, 1, 0); cyc();
        expect_out("head_on_owned", 1, 0, 4'b1011, 4'b0100, 1);

        // underflow on VC0
        do_reset();
        send(0, 1, 1); cyc();
        send(0, 1, 1); cyc();
        expect_out("under_pre", 1, 1, 4'b1110, 4'b0000, 0);
        send(0, 1, 1); cyc();
        expect_out("underflow", 1, 1, 4'b1110, 4'b0000, 1);
        credit(0); cyc();
        expect_out("under_back", 1, 0, 4'b1111, 4'b0000, 1);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk_i);
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
